// File: rtl/uart_rx_frame_assembler.sv
// uart_rx_frame_assembler
// Collects UART receiver byte strobes into header/cmd/addr/[data] frames and
// presents each complete frame on a valid/ready interface. Stray bytes before
// a header are dropped, stalled frames are aborted by an idle timeout, and
// bytes arriving while a frame waits for the consumer raise an overrun pulse.
module uart_rx_frame_assembler #(
  parameter logic [7:0]  HEADER         = 8'h01,
  parameter int unsigned TIMEOUT_CYCLES = 43200
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        RX_DONE_I,
  input  logic [7:0]  RX_DATA_I,
  output logic [7:0]  CMD_O,
  output logic [7:0]  ADDR_O,
  output logic [31:0] DATA_O,
  output logic        VALID_O,
  input  logic        READY_I,
  output logic        ERR_TIMEOUT_O,
  output logic        ERR_OVERRUN_O
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    st_idle,
    st_cmd,
    st_addr,
    st_data,
    st_out
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic [1:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic           tmo_q, tmo_d;
  logic           ovr_q, ovr_d;

  // Next-state, field capture, idle timeout and error pulse generation
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    ovr_d   = 1'b0;

    case (state_q)
      st_idle: begin
        cnt_d = '0;
        if (RX_DONE_I && (RX_DATA_I == HEADER)) begin
          state_d = st_cmd;
        end
      end

      st_cmd, st_addr, st_data: begin
        if (RX_DONE_I) begin
          // An arriving byte always beats a simultaneous timeout expiry
          cnt_d = '0;
          case (state_q)
            st_cmd: begin
              cmd_d   = RX_DATA_I;
              state_d = st_addr;
            end
            st_addr: begin
              addr_d = RX_DATA_I;
              if (cmd_q[7]) begin
                idx_d   = 2'd0;
                state_d = st_data;
              end else begin
                data_d  = '0;
                state_d = st_out;
              end
            end
            default: begin
              data_d[{idx_q, 3'b000} +: 8] = RX_DATA_I;
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                state_d = st_out;
              end
            end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = st_idle;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      st_out: begin
        cnt_d = '0;
        if (RX_DONE_I) begin
          ovr_d = 1'b1;
        end
        if (READY_I) begin
          state_d = st_idle;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = st_idle;
      end
    endcase

    valid_d = (state_d == st_out);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= st_idle;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
    end
  end

  assign CMD_O         = cmd_q;
  assign ADDR_O        = addr_q;
  assign DATA_O        = data_q;
  assign VALID_O       = valid_q;
  assign ERR_TIMEOUT_O = tmo_q;
  assign ERR_OVERRUN_O = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// Scoreboard bench for uart_rx_frame_assembler: the driver builds frames from
// field values and pushes the expected frame / error-pulse cycles; a monitor
// on the falling edge compares whatever the DUT presents against the queues.
module tb_uart_rx_frame_assembler;

  localparam logic [7:0]  HDR = 8'h01;
  localparam int unsigned T   = 100;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        ready = 1'b0;
  logic [7:0]  cmd_o, addr_o;
  logic [31:0] data_o;
  logic        valid_o, err_to, err_ov;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;

  frame_t      exp_q[$];
  int unsigned to_q[$];
  int unsigned ov_q[$];

  uart_rx_frame_assembler #(
    .HEADER(HDR),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .RX_DONE_I(rx_done),
    .RX_DATA_I(rx_data),
    .CMD_O(cmd_o),
    .ADDR_O(addr_o),
    .DATA_O(data_o),
    .VALID_O(valid_o),
    .READY_I(ready),
    .ERR_TIMEOUT_O(err_to),
    .ERR_OVERRUN_O(err_ov)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge k the bench sees cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: frames, field stability while held, and error pulse timing
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected cyc=%0d got cmd=%h addr=%h data=%h required no frame",
                   cyc, cmd_o, addr_o, data_o);
        end else if ({cmd_o, addr_o, data_o} != exp_q[0]) begin
          fails++;
          $display("FAIL frame_fields cyc=%0d got cmd=%h addr=%h data=%h required cmd=%h addr=%h data=%h",
                   cyc, cmd_o, addr_o, data_o, exp_q[0].cmd, exp_q[0].addr, exp_q[0].data);
        end
        if (ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (err_to) begin
        tests++;
        if (to_q.size() == 0) begin
          fails++;
          $display("FAIL timeout_pulse cyc=%0d got pulse required none", cyc);
        end else begin
          if (to_q[0] != cyc) begin
            fails++;
            $display("FAIL timeout_pulse got cyc=%0d required cyc=%0d", cyc, to_q[0]);
          end
          void'(to_q.pop_front());
        end
      end
      if (err_ov) begin
        tests++;
        if (ov_q.size() == 0) begin
          fails++;
          $display("FAIL overrun_pulse cyc=%0d got pulse required none", cyc);
        end else begin
          if (ov_q[0] != cyc) begin
            fails++;
            $display("FAIL overrun_pulse got cyc=%0d required cyc=%0d", cyc, ov_q[0]);
          end
          void'(ov_q.pop_front());
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) cycle();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    cycle();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic ovr_byte(input logic [7:0] b);
    send_byte(b);
    ov_q.push_back(cyc);
  endtask

  // gmode: 0 back-to-back, 1 random small gaps with occasional T-1, 2 always T-1
  // ovr: 0 none, 1 random stray bytes while held, 2 one 7E in first held cycle
  // abort: 0 complete frame, else number of bytes sent before going silent
  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d,
                            input int unsigned gmode, input int unsigned hold,
                            input int unsigned ovr, input int unsigned abort);
    logic [7:0]  b[7];
    int unsigned n;
    frame_t      f;
    b[0] = HDR; b[1] = c; b[2] = a;
    for (int k = 0; k < 4; k++) b[3+k] = d[8*k +: 8];
    n = c[7] ? 7 : 3;
    f.cmd = c; f.addr = a; f.data = c[7] ? d : 32'h0;
    if (abort != 0) begin
      for (int unsigned i = 0; i < abort; i++) begin
        send_byte(b[i]);
        if (i + 1 < abort) gap($urandom_range(0, 3));
      end
      to_q.push_back(cyc + T);
      gap(T + 4);
      return;
    end
    for (int unsigned i = 0; i < n; i++) begin
      if (i == n - 1) exp_q.push_back(f);
      send_byte(b[i]);
      if (i < n - 1) begin
        if (gmode == 2) gap(T - 1);
        else if (gmode == 1) gap(($urandom_range(0, 9) == 0) ? T - 1 : $urandom_range(0, 3));
      end
    end
    ready = 1'b0;
    for (int unsigned h = 0; h < hold; h++) begin
      if ((ovr == 2 && h == 0) || (ovr == 1 && $urandom_range(0, 2) == 0))
        ovr_byte((ovr == 2) ? 8'h7E : 8'($urandom));
      else
        cycle();
    end
    ready = 1'b1;
    if (ovr == 1 && $urandom_range(0, 2) == 0) ovr_byte(8'($urandom));
    else cycle();
    ready = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_cmd"},   {24'h0, cmd_o},  32'h0);
    chk({tag, "_addr"},  {24'h0, addr_o}, 32'h0);
    chk({tag, "_data"},  data_o,          32'h0);
    chk({tag, "_valid"}, {31'h0, valid_o}, 32'h0);
    chk({tag, "_errto"}, {31'h0, err_to},  32'h0);
    chk({tag, "_errov"}, {31'h0, err_ov},  32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
    check_zero_outputs("reset");

    // Read frame
    send_frame(8'h05, 8'h10, 32'h0, 0, 0, 0, 0);
    gap(2);
    // Write frame held for 5 cycles
    send_frame(8'h85, 8'h22, 32'hDEADBEEF, 0, 5, 0, 0);
    gap(2);
    // Preamble garbage
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
    send_frame(8'h02, 8'h03, 32'h0, 0, 0, 0, 0);
    gap(2);
    // Timeout after cmd byte, then a normal read
    send_frame(8'h85, 8'h00, 32'h0, 0, 0, 0, 2);
    send_frame(8'h06, 8'h30, 32'h0, 0, 1, 0, 0);
    gap(2);
    // Overrun while held
    send_frame(8'h07, 8'h40, 32'h0, 0, 3, 2, 0);
    // Header on the cycle right after the handshake
    send_frame(8'h08, 8'h41, 32'h0, 0, 0, 0, 0);
    gap(2);
    // Reset mid-frame
    send_byte(HDR); send_byte(8'h85); send_byte(8'h11);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_zero_outputs("midreset");
    send_frame(8'h04, 8'h20, 32'h0, 0, 0, 0, 0);
    gap(2);
    // Gaps of exactly T-1 idle cycles must not abort
    send_frame(8'h9A, 8'h55, 32'h12345678, 2, 2, 0, 0);
    gap(2);

    // Randomized frames
    for (int r = 0; r < 60; r++) begin
      logic [7:0]  c, a, g;
      logic [31:0] d;
      c = 8'($urandom); a = 8'($urandom); d = $urandom;
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        g = 8'($urandom);
        if (g == HDR) g = 8'hFF;
        send_byte(g);
        gap($urandom_range(0, 2));
      end
      if ($urandom_range(0, 7) == 0)
        send_frame(c, a, d, 1, 0, 0, $urandom_range(1, c[7] ? 6 : 2));
      else
        send_frame(c, a, d, 1, $urandom_range(0, 4), 1, 0);
      gap($urandom_range(0, 2));
    end

    gap(10);
    chk("frames_pending",   exp_q.size(), 32'h0);
    chk("timeouts_pending", to_q.size(),  32'h0);
    chk("overruns_pending", ov_q.size(),  32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_assembler.md
# uart_rx_frame_assembler

Downstream consumer of the UART receiver in the debug-UART path. Takes single-byte strobes from the receiver, hunts for a header byte, assembles a command, address and optional 32-bit data word, and presents the complete frame on a valid/ready interface to the debug command logic. It discards stray bytes before a header, aborts stalled frames with a timeout, and flags bytes lost while a frame is still pending.

## Interface
- `HEADER`, default 8'h01: frame start byte.
- `TIMEOUT_CYCLES`, default 43200: consecutive idle clock cycles mid-frame before abort. Must be at least 2. The default is roughly 10 byte times at 16x oversampling and divider 27.
- `CLK_I`  in  1: single clock. All logic is rising-edge.
- `RST_I`  in  1: synchronous, active-high reset.
- `RX_DONE_I`  in  1: one-cycle strobe from the receiver. The byte is valid on `RX_DATA_I` in the same cycle.
- `RX_DATA_I`  in  8: received byte.
- `CMD_O`  out  8: command byte. Bit 7 = write (a data phase follows).
- `ADDR_O`  out  8: address byte.
- `DATA_O`  out  32: write data, little-endian (first byte in [7:0]). Zero for reads.
- `VALID_O`  out  1: frame available.
- `READY_I`  in  1: consumer accepts the frame.
- `ERR_TIMEOUT_O`  out  1: one-cycle pulse when a frame is aborted.
- `ERR_OVERRUN_O`  out  1: one-cycle pulse when a byte is dropped during `st_out`.

## Operation
- States: `st_idle`, `st_cmd`, `st_addr`, `st_data`, `st_out`.
- A "byte" below means a cycle with `RX_DONE_I`=1.
- `st_idle`:
  - Byte == `HEADER`: go to `st_cmd`.
  - Any other byte: discard silently, no error.
- `st_cmd`: byte is latched into `CMD_O`; go to `st_addr`.
- `st_addr`: byte is latched into `ADDR_O`.
  - If `CMD_O[7]`=1: go to `st_data` and clear the 2-bit byte index.
  - Else: clear `DATA_O` and go to `st_out`.
- `st_data`:
  - Byte k is written to `DATA_O[8k+7:8k]`, with k = 0..3.
  - After k=3, go to `st_out`.
- `st_out`:
  - `VALID_O`=1. `CMD_O`, `ADDR_O` and `DATA_O` are held stable.
  - On `READY_I`=1, go to `st_idle`.
  - Any byte arriving in `st_out` is dropped and pulses `ERR_OVERRUN_O`. This includes a byte in the same cycle as the `READY_I` handshake.
- Timeout counter:
  - Width is $clog2(`TIMEOUT_CYCLES`+1).
  - Cleared on every accepted byte and whenever the state is `st_idle` or `st_out`.
  - Increments on every cycle in `st_cmd`, `st_addr` or `st_data` that has no byte.
  - When it reaches `TIMEOUT_CYCLES`-1 with no byte in that cycle: go to `st_idle` and pulse `ERR_TIMEOUT_O`. The partial frame is discarded and `VALID_O` never asserts for it.
- Simultaneous byte and timeout expiry: the byte wins and the counter clears.
- A new `HEADER` byte arriving mid-frame is treated as ordinary data. There is no resynchronisation except via timeout.
- Field registers may retain stale values outside `st_out`. Consumers qualify them with `VALID_O` only.

## Timing
- Reset (`RST_I`=1 at a clock edge): state becomes `st_idle` and counters clear. All outputs are 0 from the following cycle: `CMD_O`, `ADDR_O`, `DATA_O`, `VALID_O`, `ERR_TIMEOUT_O`, `ERR_OVERRUN_O`.
- Reset mid-frame or while `VALID_O`=1 drops the frame with no error pulse.
- Latency: `VALID_O` rises on the cycle after the strobe of the final byte (the address byte for reads, data byte 3 for writes).
- Handshake:
  - Transfer occurs on the cycle with `VALID_O`=1 and `READY_I`=1.
  - `VALID_O` is 0 on the next cycle.
  - `VALID_O` is never withdrawn without a transfer, except by reset.
  - `READY_I` is ignored while `VALID_O`=0.
- Error pulses are registered: high for exactly one cycle, on the cycle after the causing event.
- Throughput: one byte per cycle is accepted. Back-to-back strobes are legal in every assembling state.
- Frame to next frame: a `HEADER` byte may arrive on the cycle after the handshake cycle and is accepted.

## Test plan
- Read frame: bytes 01, 05, 10 with `READY_I`=1. Required: one cycle after byte 10, `VALID_O`=1 with `CMD_O`=05, `ADDR_O`=10, `DATA_O`=00000000. `VALID_O`=0 on the following cycle.
- Write frame: bytes 01, 85, 22, EF, BE, AD, DE with `READY_I` held low for 5 cycles after `VALID_O` rises. Required: `DATA_O`=DEADBEEF and `ADDR_O`=22, both stable while `VALID_O` is held until `READY_I` goes high.
- Preamble garbage: bytes 55, AA, 00, then 01, 02, 03. Required: exactly one frame, with `CMD_O`=02 and `ADDR_O`=03, and no error pulses.
- Timeout (`TIMEOUT_CYCLES`=100): bytes 01, 85, then silence. Required: `ERR_TIMEOUT_O` pulses once, 100 cycles after the 85 strobe (±1 per the counting rule), and `VALID_O` stays 0. A following full read frame completes normally.
- Overrun: complete a read frame with `READY_I`=0, then send byte 7E. Required: `ERR_OVERRUN_O` pulses once and the frame fields are unchanged. After `READY_I`=1, the state returns to `st_idle`.
- Reset mid-frame: bytes 01, 85, 11, then `RST_I` for 1 cycle, then 01, 04, 20. Required: all outputs are 0 after reset, and one frame is produced with `CMD_O`=04 and `ADDR_O`=20.
